rle_enc: RTL and testbench
==========================

# rle_enc

Run-length encoder sitting directly downstream of the sample delay FIFO in the capture path. It consumes the delayed sample stream with no backpressure and emits a compressed stream of sample words and repeat-count words to the capture memory writer. When disabled it passes samples through with one cycle of latency.

## Interface
- `DW`, 32: stream word width. Bit `DW-1` is the RLE flag; bits `DW-2:0` carry the sample or the count.
- `clk`, in, 1: system clock.
- `rst`, in, 1: synchronous, active-high reset.
- `enable`, in, 1: 1 = RLE mode, 0 = passthrough.
- `flush`, in, 1: single-cycle pulse at end of capture; emits any outstanding word.
- `sti_valid`, in, 1: input sample strobe.
- `sti_data`, in, DW: input sample.
- `sto_valid`, out, 1: output word strobe (registered).
- `sto_data`, out, DW: output word (registered).

## Operation
- **Passthrough (`enable`=0):** `sto_valid`/`sto_data` <= `sti_valid`/`sti_data` unmodified, including bit `DW-1`. Run state is held cleared.
- **RLE mode (`enable`=1).** Only `sti_data[DW-2:0]` is compared and emitted; `sti_data[DW-1]` is ignored.
- **Output formats:**
  - Value word = {1'b0, sample}.
  - Count word = {1'b1, N}, where N = number of additional repeats of the preceding value, 1..2^(DW-1)-1.
- **State:**
  - `last` (DW-1 bits), `active` (a run is open).
  - `cnt` (DW-1 bits, repeats not yet emitted).
  - `pend`/`pend_v` (one-entry value word not yet emitted).
- **Valid sample with no open run, or differing from `last`:**
  - If `cnt`>0, emit count word `cnt`.
  - Else if `pend_v`, emit `pend`.
  - The new value is emitted in the same cycle if the output slot is still free; otherwise it is written to `pend`.
  - Then `last` <= sample, `cnt` <= 0, `active` <= 1.
- **Valid sample equal to `last`:**
  - If `pend_v`, emit `pend` and clear `pend_v`.
  - `cnt` <= `cnt`+1.
  - If `cnt`+1 = 2^(DW-1)-1 (saturation), emit count word of that value in this cycle instead and set `cnt` <= 0. The run stays open.
  - A saturation event never coincides with `pend_v`=1.
- **Cycle with `sti_valid`=0:** if `pend_v`, emit `pend` and clear it.
- **Pending depth:** one entry suffices and is never overrun.
  - `pend_v`=1 only while the current run has length 1, which implies `cnt`=0.
  - At most one word is output per cycle.
- **Flush:**
  - Latched into a sticky request. It is serviced in the first cycle with `sti_valid`=0, which may be the flush cycle itself.
  - On service: emit count word if `cnt`>0, else emit `pend` if `pend_v`, else emit nothing.
  - Then clear `active`, `cnt`, `pend_v` and the request. The next sample starts a fresh run and is emitted as a value word.
- **`enable` change:** clears run state, `pend_v` and the flush request. Outstanding words are discarded; software flushes before toggling `enable`.

## Timing
- **Reset:** `sto_valid`=0, `sto_data`=0; `active`=0, `cnt`=0, `pend_v`=0, flush request = 0.
- **Latency:**
  - Any word decided in cycle t appears on `sto_valid`/`sto_data` in cycle t+1.
  - A deferred `pend` word appears 1 cycle after the first free slot.
- `sto_data` holds its last value when `sto_valid`=0.
- **Throughput:** output words ≤ input samples in every window, so no backpressure is required.
- **Reset mid-run:** all state is lost with no partial emission; `sto_valid`=0 the cycle after `rst`.

## Test plan
- **Passthrough:** `enable`=0, DW=8, samples 0x81, 0x81, 0x05 back-to-back -> same three words one cycle later, bit 7 untouched.
- **Basic runs:** `enable`=1, DW=8, valid every cycle with A,A,A,B,C where A=0x11, B=0x22, C=0x33, then `flush` -> output sequence 0x11, 0x82, 0x22, 0x33, each 1 cycle after its trigger. B is emitted via `pend` in the C cycle; C is emitted via `pend` on the idle/flush cycle.
- **Alternating pairs:** A,A,B,B,C,C back-to-back -> A, 0x81, B, 0x81, C, 0x81 (last after flush). `pend_v` never exceeds one entry.
- **Saturation:** DW=8, 200 consecutive 0x10 then 0x20, flush -> 0x10, 0xFF (127 repeats), 0x80|72 = 0xC8, 0x20.
- **Flush timing:** flush asserted coincident with a valid differing sample -> request deferred to the next idle cycle. Issue a new sample after flush -> it is emitted as a value word even if equal to the previous value.
- **Reset mid-run:** after 5 repeats, pulse `rst` -> `sto_valid`=0, no count word emitted. The next sample is emitted as a value word.

Source files
------------

// File: rtl/rle_enc.sv
// Run-length encoder for the capture path: collapses repeated samples into a
// value word followed by a repeat-count word, or passes samples through when disabled.
module rle_enc #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          flush,
  input  logic          sti_valid,
  input  logic [DW-1:0] sti_data,
  output logic          sto_valid,
  output logic [DW-1:0] sto_data
);

  localparam int SW = DW - 1;
  localparam logic [SW-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic          active;
    logic [SW-1:0] last;
    logic [SW-1:0] cnt;
    logic [SW-1:0] pend;
    logic          pend_v;
    logic          flush_req;
  } run_t;

  run_t          run_q, run_d;
  logic          sto_valid_q, sto_valid_d;
  logic [DW-1:0] sto_data_q, sto_data_d;

  logic [SW-1:0] sample;
  logic [SW-1:0] cnt_inc;
  logic          flush_now;
  logic          new_run;

  assign sample    = sti_data[SW-1:0];
  assign cnt_inc   = run_q.cnt + 1'b1;
  assign flush_now = run_q.flush_req | flush;
  assign new_run   = !run_q.active || (sample != run_q.last);

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    run_d       = run_q;
    sto_valid_d = 1'b0;
    sto_data_d  = sto_data_q;

    if (!enable) begin
      // Run state is held cleared so a later switch to RLE starts cleanly.
      run_d       = '0;
      sto_valid_d = sti_valid;
      if (sti_valid) sto_data_d = sti_data;
    end else if (sti_valid) begin
      run_d.flush_req = flush_now;
      if (new_run) begin
        if (run_q.cnt != '0) begin
          sto_valid_d  = 1'b1;
          sto_data_d   = {1'b1, run_q.cnt};
          run_d.pend   = sample;
          run_d.pend_v = 1'b1;
        end else if (run_q.pend_v) begin
          sto_valid_d  = 1'b1;
          sto_data_d   = {1'b0, run_q.pend};
          run_d.pend   = sample;
          run_d.pend_v = 1'b1;
        end else begin
          sto_valid_d  = 1'b1;
          sto_data_d   = {1'b0, sample};
          run_d.pend_v = 1'b0;
        end
        run_d.last   = sample;
        run_d.cnt    = '0;
        run_d.active = 1'b1;
      end else if (cnt_inc == CNT_MAX) begin
        // Saturated count is emitted at once; the run itself stays open.
        sto_valid_d = 1'b1;
        sto_data_d  = {1'b1, CNT_MAX};
        run_d.cnt   = '0;
      end else begin
        if (run_q.pend_v) begin
          sto_valid_d  = 1'b1;
          sto_data_d   = {1'b0, run_q.pend};
          run_d.pend_v = 1'b0;
        end
        run_d.cnt = cnt_inc;
      end
    end else if (flush_now) begin
      if (run_q.cnt != '0) begin
        sto_valid_d = 1'b1;
        sto_data_d  = {1'b1, run_q.cnt};
      end else if (run_q.pend_v) begin
        sto_valid_d = 1'b1;
        sto_data_d  = {1'b0, run_q.pend};
      end
      run_d.active    = 1'b0;
      run_d.cnt       = '0;
      run_d.pend_v    = 1'b0;
      run_d.flush_req = 1'b0;
    end else if (run_q.pend_v) begin
      sto_valid_d  = 1'b1;
      sto_data_d   = {1'b0, run_q.pend};
      run_d.pend_v = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q       <= '0;
      sto_valid_q <= 1'b0;
      sto_data_q  <= '0;
    end else begin
      run_q       <= run_d;
      sto_valid_q <= sto_valid_d;
      sto_data_q  <= sto_data_d;
    end
  end

  assign sto_valid = sto_valid_q;
  assign sto_data  = sto_data_q;

endmodule

// File: tb/tb_rle_enc.sv
// Directed bench for rle_enc (DW=8): expected words with their due cycle are
// queued when stimulus is driven and matched cycle-exactly against the output.
module tb_rle_enc;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          flush;
  logic          sti_valid;
  logic [DW-1:0] sti_data;
  logic          sto_valid;
  logic [DW-1:0] sto_data;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  rle_enc #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .flush     (flush),
    .sti_valid (sti_valid),
    .sti_data  (sti_data),
    .sto_valid (sto_valid),
    .sto_data  (sto_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Words decided in the driven cycle are due one cycle later.
  task automatic push(input logic [DW-1:0] d);
    exp_t e;
    e.data = d;
    e.cyc  = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic f);
    @(posedge clk);
    #1;
    sti_valid = v;
    sti_data  = d;
    flush     = f;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        check("out_valid", {31'd0, sto_valid}, 32'd1);
        check("out_data", {24'd0, sto_data}, {24'd0, sb[0].data});
        void'(sb.pop_front());
      end else begin
        check("idle_valid", {31'd0, sto_valid}, 32'd0);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    flush     = 1'b0;
    sti_valid = 1'b0;
    sti_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_valid", {31'd0, sto_valid}, 32'd0);
    check("reset_data", {24'd0, sto_data}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Passthrough keeps bit 7 intact
    drive(1'b1, 8'h81, 1'b0); push(8'h81);
    drive(1'b1, 8'h81, 1'b0); push(8'h81);
    drive(1'b1, 8'h05, 1'b0); push(8'h05);
    drive(1'b0, 8'h00, 1'b0);
    enable = 1'b1;
    drive(1'b0, 8'h00, 1'b0);

    // Basic runs: A,A,A,B,C then flush
    drive(1'b1, 8'h11, 1'b0); push(8'h11);
    drive(1'b1, 8'h11, 1'b0);
    drive(1'b1, 8'h11, 1'b0);
    drive(1'b1, 8'h22, 1'b0); push(8'h82);
    drive(1'b1, 8'h33, 1'b0); push(8'h22);
    drive(1'b0, 8'h00, 1'b1); push(8'h33);
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b0);

    // Alternating pairs; bit 7 of the input is ignored in RLE mode
    drive(1'b1, 8'h11, 1'b0); push(8'h11);
    drive(1'b1, 8'h91, 1'b0);
    drive(1'b1, 8'h22, 1'b0); push(8'h81);
    drive(1'b1, 8'h22, 1'b0); push(8'h22);
    drive(1'b1, 8'h33, 1'b0); push(8'h81);
    drive(1'b1, 8'h33, 1'b0); push(8'h33);
    drive(1'b0, 8'h00, 1'b1); push(8'h81);
    drive(1'b0, 8'h00, 1'b0);

    // Saturation: 200 x 0x10 gives 0x10, 0xFF (127), 0xC8 (72)
    drive(1'b1, 8'h10, 1'b0); push(8'h10);
    for (int i = 0; i < 199; i++) begin
      drive(1'b1, 8'h10, 1'b0);
      if (i == 126) push(8'hFF);
    end
    drive(1'b1, 8'h20, 1'b0); push(8'hC8);
    drive(1'b0, 8'h00, 1'b1); push(8'h20);
    drive(1'b0, 8'h00, 1'b0);

    // Flush coincident with a differing sample is deferred to the next idle cycle
    drive(1'b1, 8'h50, 1'b0); push(8'h50);
    drive(1'b1, 8'h50, 1'b0);
    drive(1'b1, 8'h60, 1'b1); push(8'h81);
    drive(1'b1, 8'h60, 1'b0); push(8'h60);
    drive(1'b0, 8'h00, 1'b0); push(8'h81);
    drive(1'b1, 8'h60, 1'b0); push(8'h60);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);

    // Reset mid-run drops the open run without emitting a count
    drive(1'b1, 8'h44, 1'b0); push(8'h44);
    repeat (5) drive(1'b1, 8'h44, 1'b0);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    sti_valid = 1'b0;
    @(negedge clk);
    check("rst_midrun_valid", {31'd0, sto_valid}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b1, 8'h44, 1'b0); push(8'h44);
    drive(1'b0, 8'h00, 1'b1);
    repeat (4) drive(1'b0, 8'h00, 1'b0);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
